// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width constant and count type for the pulse divider
package divider_pkg;
  localparam int DIV_WIDTH = 32;
  typedef logic [DIV_WIDTH-1:0] count_t;
endpackage

// File: rtl/divider_serial_shift_reg.sv
// rtl/divider_serial_shift_reg.sv - MSB-first serial load register with clear
import divider_pkg::*;

module serial_shift_reg #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             shift_edge,
  input  logic             shift_enable,
  input  logic             clear,
  input  logic             data,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      value <= '0;
    end else if (shift_edge && shift_enable) begin
      value <= {value[WIDTH-2:0], data};
    end
  end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - divide-by-N laser pulse divider with optional row gating and pixel count
import divider_pkg::*;

module divider #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic pulse_clock,
  input  logic external_reset,
  input  logic enable,
  input  logic sr_data,
  input  logic sr_data_clock,
  input  logic sr_div_data_enable,
  input  logic sr_div_data_reset,
  input  logic rowpack_enable,
  input  logic sr_row_data_enable,
  input  logic sr_row_data_reset,
  input  logic row_max_velocity,
  input  logic row_starting,
  input  logic reset_row,
  output logic row_complete,
  output logic divided_clock
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             sr_clk_q;
  logic             strobe_edge;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] row_reg;
  logic [WIDTH-1:0] div_cnt;
  logic [WIDTH-1:0] pixel_cnt;
  logic [WIDTH-1:0] pixel_next;
  logic             advance;
  logic             terminal;

  assign strobe_edge = sr_data_clock & ~sr_clk_q;
  assign advance     = enable & (~rowpack_enable | (row_max_velocity & ~row_complete));
  // A zero divisor must never match, so the compare is qualified rather than wrapped.
  assign terminal    = (divisor_reg != '0) && (div_cnt == divisor_reg - ONE);
  assign pixel_next  = pixel_cnt + ONE;

  serial_shift_reg #(.WIDTH(WIDTH)) u_div_sr (
    .clk          (pulse_clock),
    .resetn       (external_reset),
    .shift_edge   (strobe_edge),
    .shift_enable (sr_div_data_enable),
    .clear        (sr_div_data_reset),
    .data         (sr_data),
    .value        (divisor_reg)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_row_sr (
    .clk          (pulse_clock),
    .resetn       (external_reset),
    .shift_edge   (strobe_edge),
    .shift_enable (sr_row_data_enable),
    .clear        (sr_row_data_reset),
    .data         (sr_data),
    .value        (row_reg)
  );

  always_ff @(posedge pulse_clock) begin
    if (!external_reset) begin
      sr_clk_q      <= 1'b0;
      div_cnt       <= '0;
      pixel_cnt     <= '0;
      row_complete  <= 1'b0;
      divided_clock <= 1'b0;
    end else begin
      sr_clk_q <= sr_data_clock;

      if (reset_row || row_starting || !enable) begin
        div_cnt       <= '0;
        divided_clock <= 1'b0;
      end else if (advance) begin
        if (terminal) begin
          div_cnt       <= '0;
          divided_clock <= 1'b1;
        end else begin
          div_cnt       <= div_cnt + ONE;
          divided_clock <= 1'b0;
        end
      end else begin
        divided_clock <= 1'b0;
      end

      // Row progress counts emitted pulses; a row target of zero means unlimited.
      if (reset_row) begin
        pixel_cnt    <= '0;
        row_complete <= 1'b0;
      end else if (rowpack_enable && divided_clock) begin
        pixel_cnt <= pixel_next;
        if (row_reg != '0 && pixel_next == row_reg) begin
          row_complete <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed table-driven bench for the pulse divider
import divider_pkg::*;

module tb_divider;

  logic clk = 1'b0;
  logic resetn;
  logic enable, sr_data, sr_data_clock, sr_div_data_enable, sr_div_data_reset;
  logic rowpack_enable, sr_row_data_enable, sr_row_data_reset;
  logic row_max_velocity, row_starting, reset_row;
  logic row_complete, divided_clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    count_t div;
    int     cycles;
    int     exp_pulses;
    int     exp_first;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  divider dut (
    .pulse_clock        (clk),
    .external_reset     (resetn),
    .enable             (enable),
    .sr_data            (sr_data),
    .sr_data_clock      (sr_data_clock),
    .sr_div_data_enable (sr_div_data_enable),
    .sr_div_data_reset  (sr_div_data_reset),
    .rowpack_enable     (rowpack_enable),
    .sr_row_data_enable (sr_row_data_enable),
    .sr_row_data_reset  (sr_row_data_reset),
    .row_max_velocity   (row_max_velocity),
    .row_starting       (row_starting),
    .reset_row          (reset_row),
    .row_complete       (row_complete),
    .divided_clock      (divided_clock)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic shift_word(input count_t val, input logic div_en, input logic row_en);
    count_t v;
    v = val;
    sr_div_data_enable = div_en;
    sr_row_data_enable = row_en;
    for (int i = DIV_WIDTH - 1; i >= 0; i--) begin
      sr_data       = v[i];
      sr_data_clock = 1'b1;
      step();
      sr_data_clock = 1'b0;
      step();
    end
    sr_div_data_enable = 1'b0;
    sr_row_data_enable = 1'b0;
  endtask

  // Runs with enable high for n cycles; gaps between pulses must equal div.
  task automatic run(input int n, input count_t div, input string name,
                     output int pulses, output int first);
    int last;
    pulses = 0;
    first  = 0;
    last   = 0;
    enable = 1'b1;
    for (int c = 1; c <= n; c++) begin
      step();
      if (divided_clock) begin
        if (pulses == 0) first = c;
        else check({name, "_gap"}, c - last, div);
        last = c;
        pulses++;
      end
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    int pulses, first, last_pulse, rc_first;

    vecs[0] = '{div: 0,  cycles: 40, exp_pulses: 0, exp_first: 0};
    vecs[1] = '{div: 1,  cycles: 8,  exp_pulses: 8, exp_first: 1};
    vecs[2] = '{div: 3,  cycles: 12, exp_pulses: 4, exp_first: 3};
    vecs[3] = '{div: 10, cycles: 50, exp_pulses: 5, exp_first: 10};
    vecs[4] = '{div: 5,  cycles: 23, exp_pulses: 4, exp_first: 5};

    // Reset with garbage on every input.
    resetn = 1'b0;
    enable = 1'b1; sr_data = 1'b1; sr_data_clock = 1'b1; sr_div_data_enable = 1'b1;
    sr_div_data_reset = 1'b0; rowpack_enable = 1'b1; sr_row_data_enable = 1'b1;
    sr_row_data_reset = 1'b0; row_max_velocity = 1'b1; row_starting = 1'b0; reset_row = 1'b0;
    step();
    sr_data_clock = 1'b0;
    step();
    check("reset_divided_clock", divided_clock, 0);
    check("reset_row_complete", row_complete, 0);
    check("reset_divisor_reg", dut.divisor_reg, 0);
    enable = 1'b0; sr_data = 1'b0; sr_div_data_enable = 1'b0;
    rowpack_enable = 1'b0; sr_row_data_enable = 1'b0; row_max_velocity = 1'b0;
    resetn = 1'b1;
    step();
    run(30, 0, "post_reset", pulses, first);
    check("post_reset_pulses", pulses, 0);

    // Table of divisor runs.
    for (int k = 0; k < 5; k++) begin
      shift_word(vecs[k].div, 1'b1, 1'b0);
      check($sformatf("v%0d_divisor_reg", k), dut.divisor_reg, vecs[k].div);
      run(vecs[k].cycles, vecs[k].div, $sformatf("v%0d", k), pulses, first);
      check($sformatf("v%0d_pulses", k), pulses, vecs[k].exp_pulses);
      check($sformatf("v%0d_first", k), first, vecs[k].exp_first);
    end

    // Rowpack: divisor 10, row 10.
    shift_word(32'd10, 1'b1, 1'b0);
    shift_word(32'd10, 1'b0, 1'b1);
    check("row_reg_load", dut.row_reg, 10);
    rowpack_enable = 1'b1;
    reset_row = 1'b1;
    step();
    reset_row = 1'b0;
    enable = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (divided_clock) pulses++;
    end
    check("gated_pulses", pulses, 0);
    row_max_velocity = 1'b1;
    pulses = 0; last_pulse = 0; rc_first = 0;
    for (int c = 1; c <= 275; c++) begin
      step();
      if (divided_clock) begin pulses++; last_pulse = c; end
      if (row_complete && rc_first == 0) rc_first = c;
    end
    check("row1_pulses", pulses, 10);
    check("row1_last_pulse", last_pulse, 100);
    check("row1_complete_cycle", rc_first, 101);
    check("row1_complete_held", row_complete, 1);

    reset_row = 1'b1;
    step();
    reset_row = 1'b0;
    check("reset_row_clears", row_complete, 0);
    pulses = 0;
    for (int c = 1; c <= 325; c++) begin
      step();
      if (divided_clock) pulses++;
    end
    check("row2_pulses", pulses, 10);
    check("row2_complete", row_complete, 1);
    enable = 1'b0; rowpack_enable = 1'b0; row_max_velocity = 1'b0;
    step();

    // Phase realignment with divisor 3.
    shift_word(32'd3, 1'b1, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 4; c++) step();
    row_starting = 1'b1;
    step();
    check("row_starting_forces_low", divided_clock, 0);
    row_starting = 1'b0;
    first = 0;
    for (int c = 1; c <= 10 && first == 0; c++) begin
      step();
      if (divided_clock) first = c;
    end
    check("realign_first_pulse", first, 3);
    enable = 1'b0;
    step();

    // Divisor clear during shifting.
    sr_div_data_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sr_data = 1'b1;
      sr_div_data_reset = (i >= 16);
      sr_data_clock = 1'b1;
      step();
      sr_data_clock = 1'b0;
      step();
    end
    sr_div_data_enable = 1'b0;
    check("div_clear_priority", dut.divisor_reg, 0);
    sr_div_data_reset = 1'b0;
    run(30, 0, "cleared", pulses, first);
    check("cleared_pulses", pulses, 0);

    // Both registers shifted together.
    shift_word(32'h0000_0006, 1'b1, 1'b1);
    check("both_divisor", dut.divisor_reg, 6);
    check("both_row", dut.row_reg, 6);
    run(20, 6, "both_run", pulses, first);
    check("both_run_pulses", pulses, 3);
    sr_row_data_reset = 1'b1;
    step();
    sr_row_data_reset = 1'b0;
    check("row_clear", dut.row_reg, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Programmable integer clock divider for a laser pulse train. It emits one output pulse for every N input pulses, with N loaded serially over a shift-register interface. An optional "rowpack" mode gates output pulses to the constant-velocity region of a stage row and stops after a programmed pixel count per row. It sits between the laser pulse source and the pixel-trigger logic.

Parameters:
WIDTH, 32, bit width of the divisor register, row-pixel register and internal counters.

Ports:
pulse_clock  input  1  sole clock (laser pulse train); all logic on rising edge
external_reset  input  1  synchronous, active-low reset
enable  input  1  divider run enable
sr_data  input  1  serial data bit, MSB first
sr_data_clock  input  1  serial strobe, sampled in the pulse_clock domain
sr_div_data_enable  input  1  selects the divisor register for shifting
sr_div_data_reset  input  1  synchronous clear of the divisor register
rowpack_enable  input  1  enables row gating and counting
sr_row_data_enable  input  1  selects the row-pixel register for shifting
sr_row_data_reset  input  1  synchronous clear of the row-pixel register
row_max_velocity  input  1  stage at constant velocity; gate for output in rowpack mode
row_starting  input  1  realigns divider phase (counter to 0) while high
reset_row  input  1  clears row progress
row_complete  output  1  row pixel target reached
divided_clock  output  1  divided output, one pulse_clock cycle wide

Behaviour:
- Reset (external_reset==0 at a rising edge): clear divisor_reg, row_reg, div counter, pixel counter, sr_data_clock sample register and row_complete. divided_clock=0, row_complete=0. Reset overrides every other input.
- Serial load:
  - Register sr_data_clock every cycle.
  - A strobe edge is prev==0 and current==1. Each level must be held for at least 1 pulse_clock cycle.
  - On a strobe edge with sr_div_data_enable=1: divisor_reg <= {divisor_reg[WIDTH-2:0], sr_data}.
  - On a strobe edge with sr_row_data_enable=1: row_reg shifts the same way. Both may shift on the same edge.
  - The matching *_reset clear has priority over shifting. After 32 edges, the last bit shifted is the LSB.
- Divider core:
  - advance = enable & (~rowpack_enable | (row_max_velocity & ~row_complete)).
  - When enable=0: counter held at 0 and divided_clock=0.
  - When advance=1: if counter == divisor_reg-1, then counter <= 0 and divided_clock <= 1 for one cycle. Otherwise counter++ and divided_clock <= 0.
  - When advance=0: counter holds and divided_clock=0.
  - First pulse occurs N cycles after advance rises: one registered output cycle of latency, with counter starting from 0.
  - divisor_reg==0: divided_clock never asserts. divisor_reg==1: divided_clock high every advancing cycle.
  - Counter compare is WIDTH-bit unsigned.
- Phase alignment: row_starting=1 forces counter <= 0 and divided_clock <= 0. This takes priority over advance.
- Rowpack:
  - When rowpack_enable=1, each divided_clock pulse increments pixel_cnt.
  - When pixel_cnt reaches row_reg (the pulse that makes pixel_cnt==row_reg), row_complete <= 1 on the following cycle and stays high.
  - While row_complete=1, no further pulses are generated.
  - row_reg==0: unlimited; row_complete never asserts.
  - reset_row=1: pixel_cnt <= 0, row_complete <= 0, counter <= 0. Divisor and row registers are kept.
  - reset_row takes priority over a simultaneous terminal pulse.
  - When rowpack_enable=0: pixel_cnt and row_complete hold their values and gating is bypassed.
- Changing divisor_reg mid-run: the new value takes effect at the next compare. If counter >= new divisor-1, the counter wraps at the WIDTH-bit overflow; software must shift new values only with enable=0.

Decomposition:
- Shared package: WIDTH constant and a typedef for the WIDTH-bit count type.
- One sub-module, serial_shift_reg: edge-qualified shift enable, clear, WIDTH-bit parallel output. Instantiate it twice (divisor, row); a single shared strobe edge detector lives in the top.

Test Plan:
- Reset low for 2 cycles with garbage inputs -> divided_clock=0, row_complete=0. After release, a zero divisor yields no output pulses.
- Shift 32'd10 MSB-first with sr_div_data_enable, then enable=1 for 50 cycles -> 5 one-cycle pulses exactly 10 cycles apart, first pulse 10 cycles after enable.
- Divisor 10, row 10, rowpack_enable=1, row_max_velocity low for 25 cycles -> no pulses. Raise it for 275 cycles -> exactly 10 pulses; row_complete rises 1 cycle after the 10th pulse; no more pulses afterwards.
- After the previous test, pulse reset_row for 1 cycle -> row_complete=0. Raise row_max_velocity again for 325 cycles -> 10 more pulses, then row_complete=1.
- Divisor 1 and divisor 3 runs -> pulses every cycle and every 3rd cycle. Assert row_starting mid-count -> next pulse exactly N cycles after row_starting falls.
- Assert sr_div_data_reset during shifting -> divisor_reg=0. Shift with both enables high -> both registers receive the same value.
